mux_n: RTL and testbench

- Parameterised N-to-1 word multiplexer; the default is ten 5-bit data inputs and a 4-bit select.
- Output q is a purely combinational function of the inputs and select, with zero latency.
- A clocked side path gives a registered copy of the selected word, an out-of-range select flag and a sticky error flag.
- Used as a generic selector in datapath and display logic.

---
 rtl/mux_n_pkg.sv | 8 +
 rtl/mux_n_if.sv | 17 +
 rtl/mux_n_reg.sv | 30 +++
 rtl/mux_n.sv | 56 +++++
 tb/tb_mux_n.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mux_n_pkg.sv
// Shared constants and word type for the N-to-1 selector and its users.
package mux_pkg;
    localparam int MUX_WIDTH = 5;
    localparam int MUX_N     = 10;
    localparam int MUX_SEL_W = 4;

    typedef logic [MUX_WIDTH-1:0] word_t;
endpackage

// File: rtl/mux_n_if.sv
// Bundle of the selector's data, select and result signals for hookup in benches and wrappers.
interface mux_n_if
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH,
    parameter int SEL_W = MUX_SEL_W
);
    logic [WIDTH-1:0] d [10];
    logic [SEL_W-1:0] s;
    logic [WIDTH-1:0] q;
    logic             sel_err;
    logic [WIDTH-1:0] q_r;
    logic             err_sticky;

    modport master (output d, output s, input q, input sel_err, input q_r, input err_sticky);
    modport slave  (input d, input s, output q, output sel_err, output q_r, output err_sticky);
endinterface

// File: rtl/mux_n_reg.sv
// Register stage: one-cycle copy of the selected word plus a sticky out-of-range flag.
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_err,
    output logic [WIDTH-1:0] o_q_r,
    output logic             o_err_sticky
);
    logic [WIDTH-1:0] r_q;
    logic             r_err_sticky;

    // Reset takes priority over a simultaneous out-of-range select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q          <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            r_q          <= i_q;
            r_err_sticky <= r_err_sticky | i_err;
        end
    end

    assign o_q_r        = r_q;
    assign o_err_sticky = r_err_sticky;
endmodule

// File: rtl/mux_n.sv
// Ten-input word selector: combinational q/sel_err plus a registered side path.
module mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH,
    parameter int N     = MUX_N,
    parameter int SEL_W = MUX_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic [WIDTH-1:0] i5,
    input  logic [WIDTH-1:0] i6,
    input  logic [WIDTH-1:0] i7,
    input  logic [WIDTH-1:0] i8,
    input  logic [WIDTH-1:0] i9,
    input  logic [SEL_W-1:0] s,
    output logic [WIDTH-1:0] q,
    output logic             sel_err,
    output logic [WIDTH-1:0] q_r,
    output logic             err_sticky
);
    logic [WIDTH-1:0] w_in_arr [10];
    logic [WIDTH-1:0] w_q;
    logic             w_sel_err;

    assign w_in_arr = '{i0, i1, i2, i3, i4, i5, i6, i7, i8, i9};

    // Compare-and-select rather than direct indexing so an unknown or
    // out-of-range select yields zero instead of X.
    always_comb begin
        w_q = '0;
        for (int k = 0; k < 10; k++) begin
            if (k < N && s == SEL_W'(k))
                w_q = w_in_arr[k];
        end
    end

    assign w_sel_err = (32'(s) >= N);

    assign q       = w_q;
    assign sel_err = w_sel_err;

    mux_n_reg #(.WIDTH(WIDTH)) u_reg (
        .clk          (clk),
        .rst          (rst),
        .i_q          (w_q),
        .i_err        (w_sel_err),
        .o_q_r        (q_r),
        .o_err_sticky (err_sticky)
    );
endmodule

// File: tb/tb_mux_n.sv
// Randomised scoreboard bench for mux_n: driver pushes expectations, monitors pop and compare.
module tb_mux_n;
    import mux_pkg::*;

    typedef struct {
        logic [4:0] q;
        logic       err;
        logic       chk_reg;
        logic [4:0] qr;
        logic       st;
    } comb_exp_t;

    typedef struct {
        logic [4:0] qr;
        logic       st;
    } reg_exp_t;

    logic clk;
    logic rst;
    mux_n_if #(.WIDTH(5), .SEL_W(4)) bus ();

    mux_n dut (
        .clk        (clk),
        .rst        (rst),
        .i0         (bus.d[0]),
        .i1         (bus.d[1]),
        .i2         (bus.d[2]),
        .i3         (bus.d[3]),
        .i4         (bus.d[4]),
        .i5         (bus.d[5]),
        .i6         (bus.d[6]),
        .i7         (bus.d[7]),
        .i8         (bus.d[8]),
        .i9         (bus.d[9]),
        .s          (bus.s),
        .q          (bus.q),
        .sel_err    (bus.sel_err),
        .q_r        (bus.q_r),
        .err_sticky (bus.err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    comb_exp_t comb_q [$];
    reg_exp_t  reg_q  [$];
    event      ev_comb;

    // Reference model state
    logic [4:0] m_in [10];
    logic       m_valid = 1'b0;
    logic [4:0] m_qr    = '0;
    logic       m_st    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] sv);
        comb_exp_t e;
        reg_exp_t  re;
        @(negedge clk);
        rst = r;
        bus.s = sv;
        for (int k = 0; k < 10; k++) bus.d[k] = m_in[k];
        e.q       = (sv < 10) ? m_in[sv] : 5'd0;
        e.err     = (sv >= 10);
        e.chk_reg = m_valid;
        e.qr      = m_qr;
        e.st      = m_st;
        comb_q.push_back(e);
        #1 -> ev_comb;
        if (r) begin
            m_qr = '0; m_st = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_qr = e.q; m_st = m_st | e.err;
        end
        if (m_valid) begin
            re.qr = m_qr; re.st = m_st;
            reg_q.push_back(re);
        end
    endtask

    // Combinational monitor: q/sel_err one time unit after the change, and
    // the registers still holding their pre-edge values.
    initial begin
        comb_exp_t e;
        forever begin
            @(ev_comb);
            if (comb_q.size() == 0) begin
                chk("comb_queue_empty", 1, 0);
            end else begin
                e = comb_q.pop_front();
                chk("q", 32'(bus.q), 32'(e.q));
                chk("sel_err", 32'(bus.sel_err), 32'(e.err));
                if (e.chk_reg) begin
                    chk("q_r_pre_edge", 32'(bus.q_r), 32'(e.qr));
                    chk("err_sticky_pre_edge", 32'(bus.err_sticky), 32'(e.st));
                end
            end
        end
    end

    // Registered monitor: one pop per edge once reset has been applied.
    initial begin
        reg_exp_t re;
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() != 0) begin
                re = reg_q.pop_front();
                chk("q_r", 32'(bus.q_r), 32'(re.qr));
                chk("err_sticky", 32'(bus.err_sticky), 32'(re.st));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] base [10];
        base = '{5'b10000, 5'b10001, 5'b00100, 5'b00010, 5'b00001,
                 5'b01010, 5'b01111, 5'b01010, 5'b00011, 5'b01000};
        rst = 1'b0;
        bus.s = '0;
        for (int k = 0; k < 10; k++) begin
            m_in[k] = base[k];
            bus.d[k] = base[k];
        end

        // Directed selects before any reset: only combinational outputs defined.
        drive(1'b0, 4'd0);
        drive(1'b0, 4'd1);
        drive(1'b0, 4'd3);
        drive(1'b0, 4'd9);
        for (int k = 0; k < 10; k++) drive(1'b0, 4'(k));

        // Reset, then registered copy of s=3.
        drive(1'b1, 4'd0);
        drive(1'b0, 4'd3);
        drive(1'b0, 4'd3);

        // Out-of-range sets the sticky flag; valid selects leave it high.
        drive(1'b0, 4'd10);
        drive(1'b0, 4'd0);
        drive(1'b0, 4'd0);
        drive(1'b0, 4'd5);

        // Reset held with out-of-range select: reset wins.
        drive(1'b1, 4'd15);
        drive(1'b1, 4'd15);
        drive(1'b0, 4'd2);

        // Random traffic with occasional mid-operation resets.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 10; k++) m_in[k] = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)));
        end

        repeat (3) @(negedge clk);
        chk("drain", 32'(comb_q.size() + reg_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
